// File: rtl/ika32010_pkg.sv
// ika32010_pkg: shared constants and helpers for the IKA32010 external bus responder
package ika32010_pkg;
  localparam logic [11:0] PORT_WINDOW_MASK = 12'hFF8;
  localparam logic [15:0] NOP_WORD = 16'h7F80;
  localparam int ERR_UNDERRUN = 0;
  localparam int ERR_OVERRUN = 1;
  localparam int ERR_COLLIDE = 2;
  localparam int STB_MEN = 0;
  localparam int STB_DEN = 1;
  localparam int STB_WE = 2;
  function automatic logic in_port_window(input logic [11:0] addr);
    return (addr & PORT_WINDOW_MASK) == 12'h000;
  endfunction
endpackage

// File: rtl/ika32010_bus_edge.sv
// ika32010_bus_edge: strobe history registers with fall/rise pulses for MEN_n/DEN_n/WE_n
module ika32010_bus_edge (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] stb_n_i,
  output logic [2:0] fall_o,
  output logic [2:0] rise_o
);
  logic [2:0] hist_q;
  logic primed_q;
  // The first cycle after reset only seeds history, so a strobe held low through reset is not seen as a fresh fall.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hist_q <= '1;
      primed_q <= 1'b0;
    end else begin
      hist_q <= stb_n_i;
      primed_q <= 1'b1;
    end
  assign fall_o = primed_q ? (hist_q & ~stb_n_i) : '0;
  assign rise_o = primed_q ? (~hist_q & stb_n_i) : '0;
endmodule

// File: rtl/ika32010_ext_bus_responder.sv
// ika32010_ext_bus_responder: program RAM, IN/OUT ports and host load path on the IKA32010 external bus
module ika32010_ext_bus_responder
  import ika32010_pkg::*;
#(
  parameter int AW = 12,
  parameter logic [15:0] INIT_WORD = NOP_WORD
) (
  input  logic         i_EMUCLK,
  input  logic         i_RS_n,
  input  logic         i_MEN_n,
  input  logic         i_DEN_n,
  input  logic         i_WE_n,
  input  logic [11:0]  i_ADDR,
  input  logic [15:0]  i_DOUT,
  output logic [15:0]  o_DIN,
  input  logic         i_LD_EN,
  input  logic [11:0]  i_LD_ADDR,
  input  logic [15:0]  i_LD_DATA,
  input  logic [7:0]   i_IN_WR,
  input  logic [15:0]  i_IN_DATA,
  output logic [7:0]   o_IN_FULL,
  output logic [7:0]   o_IN_ACK,
  output logic [7:0]   o_OUT_STB,
  output logic [127:0] o_OUT_DATA,
  output logic [2:0]   o_ERR
);
  logic [2:0] fall, rise;
  logic [15:0] mem [2**AW];
  logic [15:0] din_q, din_d, wd_q;
  logic [11:0] wa_q;
  logic [2:0] port_q, err_q, err_d;
  logic armed_q, armed_d, capture, commit, port_commit, ram_commit, ram_we;
  logic [AW-1:0] ram_wa;
  logic [15:0] ram_wd;
  logic [7:0][15:0] hold_q, hold_d, out_q, out_d;
  logic [7:0] full_q, full_d, ack_q, ack_d, stb_q, stb_d;
  logic unused_edges;

  ika32010_bus_edge u_edge (
    .clk    (i_EMUCLK),
    .rst_n  (i_RS_n),
    .stb_n_i({i_WE_n, i_DEN_n, i_MEN_n}),
    .fall_o (fall),
    .rise_o (rise)
  );

  assign unused_edges = ^{fall[STB_MEN], fall[STB_DEN], rise[STB_MEN]};
  assign capture = ~i_WE_n & (armed_q | fall[STB_WE]);
  assign commit = rise[STB_WE] & armed_q;
  assign port_commit = commit & in_port_window(wa_q);
  assign ram_commit = commit & ~in_port_window(wa_q);
  assign armed_d = commit ? 1'b0 : (armed_q | fall[STB_WE]);

  // Host load owns the single write port; a colliding bus write is dropped.
  assign ram_we = i_LD_EN | ram_commit;
  assign ram_wa = i_LD_EN ? i_LD_ADDR[AW-1:0] : wa_q[AW-1:0];
  assign ram_wd = (i_LD_EN ? i_LD_DATA : wd_q) ^ INIT_WORD;

  // Words are stored XORed with INIT_WORD so all-zero power-up contents read back as INIT_WORD.
  always_ff @(posedge i_EMUCLK)
    if (ram_we) mem[ram_wa] <= ram_wd;

  assign din_d = ~i_MEN_n ? (mem[i_ADDR[AW-1:0]] ^ INIT_WORD) :
                 ~i_DEN_n ? hold_q[i_ADDR[2:0]] : din_q;

  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    ack_d = '0;
    err_d = '0;
    stb_d = '0;
    out_d = out_q;
    if (rise[STB_DEN]) begin
      if (full_q[port_q]) begin
        full_d[port_q] = 1'b0;
        ack_d[port_q] = 1'b1;
      end else err_d[ERR_UNDERRUN] = 1'b1;
    end
    // Pushes are applied after the consume so a same-cycle push leaves the port full.
    for (int p = 0; p < 8; p++)
      if (i_IN_WR[p]) begin
        hold_d[p] = i_IN_DATA;
        full_d[p] = 1'b1;
        err_d[ERR_OVERRUN] = err_d[ERR_OVERRUN] | full_q[p];
      end
    if (port_commit) begin
      out_d[wa_q[2:0]] = wd_q;
      stb_d[wa_q[2:0]] = 1'b1;
    end
    err_d[ERR_COLLIDE] = ram_commit & i_LD_EN;
  end

  always_ff @(posedge i_EMUCLK or negedge i_RS_n)
    if (!i_RS_n) begin
      din_q <= '0;
      hold_q <= '0;
      full_q <= '0;
      ack_q <= '0;
      err_q <= '0;
      stb_q <= '0;
      out_q <= '0;
      armed_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
      port_q <= '0;
    end else begin
      din_q <= din_d;
      hold_q <= hold_d;
      full_q <= full_d;
      ack_q <= ack_d;
      err_q <= err_d;
      stb_q <= stb_d;
      out_q <= out_d;
      armed_q <= armed_d;
      if (capture) begin
        wa_q <= i_ADDR;
        wd_q <= i_DOUT;
      end
      if (~i_DEN_n) port_q <= i_ADDR[2:0];
    end

  assign o_DIN = din_q;
  assign o_IN_FULL = full_q;
  assign o_IN_ACK = ack_q;
  assign o_OUT_STB = stb_q;
  assign o_OUT_DATA = out_q;
  assign o_ERR = err_q;
endmodule

// File: doc/ika32010_ext_bus_responder.md
Name: ika32010_ext_bus_responder

Overview:
- Synthesizable far end of the IKA32010 controller's external bus. Same clock domain as the controller.
- Serves instruction fetches (o_MEN_n) and TBLR reads from an internal program RAM.
- Serves IN (o_DEN_n) from eight host-fed input ports. Commits OUT/TBLW (o_WE_n) writes to eight output-port registers or to program RAM.
- Replaces ad-hoc bench memory models. Also the board-level glue for cores built on IKA32010.

Parameters:
- AW, 12, program RAM address width; depth = 2**AW words. AW ≤ 12; upper ADDR bits are ignored.
- INIT_WORD, 16'h7F80, RAM contents after power-up (NOP). RAM is not cleared by reset.

Ports:
- i_EMUCLK  in  1  system clock, same as the controller.
- i_RS_n  in  1  reset; asynchronous, active-low.
- i_MEN_n  in  1  controller program-memory strobe.
- i_DEN_n  in  1  controller data strobe (IN).
- i_WE_n  in  1  controller write strobe (OUT/TBLW).
- i_ADDR  in  12  controller address.
- i_DOUT  in  16  controller write data.
- o_DIN  out  16  read data to the controller.
- i_LD_EN  in  1  host RAM-load strobe.
- i_LD_ADDR  in  12  host RAM-load address.
- i_LD_DATA  in  16  host RAM-load data.
- i_IN_WR  in  8  per-port host push strobe.
- i_IN_DATA  in  16  host push data, shared by all ports.
- o_IN_FULL  out  8  per-port holding-register-valid flags.
- o_IN_ACK  out  8  one-cycle pulse when the controller consumes a port.
- o_OUT_STB  out  8  one-cycle pulse on an output-port commit.
- o_OUT_DATA  out  128  output-port registers; port p occupies bits [16p+15:16p].
- o_ERR  out  3  one-cycle pulses: [0] underrun, [1] overrun, [2] collide.

Behaviour:
- Reset values: o_DIN=16'h0000; o_IN_FULL=0; o_IN_ACK=0; o_OUT_STB=0; o_OUT_DATA=0; o_ERR=0.
- Reset also clears: port holding registers, write-armed flag, internal strobe-history registers (set to 1).
- Address decode:
  - Port window is ADDR[11:3]==0; port index = ADDR[2:0].
  - Writes in the window go to output ports; all other writes go to RAM[ADDR[AW-1:0]]. RAM words 0x000–0x007 cannot be written by TBLW.
- Read path, registered, 1 EMUCLK latency:
  - MEN_n=0: o_DIN ← RAM[ADDR].
  - DEN_n=0: o_DIN ← port holding register.
  - Both strobes high: o_DIN holds its last value.
  - Both strobes low: MEN_n wins.
  - Data is valid well before the controller samples (one controller phase = 4 EMUCLK).
- IN consume:
  - Triggered on the DEN_n rising edge (internal history register).
  - If the addressed port is full: clear its FULL bit, pulse o_IN_ACK[p].
  - If empty: o_DIN already returned the stale holding value; pulse o_ERR[0]. FULL is unchanged.
- Host push, i_IN_WR[p]:
  - Loads the holding register and sets FULL.
  - If FULL was already set, the value is overwritten and o_ERR[1] pulses.
  - Push and consume on the same cycle: the push wins, FULL ends at 1, o_IN_ACK still pulses.
  - Several i_IN_WR bits set: every selected port loads the same data.
- Write path:
  - WE_n falling edge sets the armed flag.
  - While WE_n is low and armed, address and data are captured every cycle.
  - WE_n rising edge while armed commits the last captured values and clears armed.
  - Port commit: o_OUT_DATA[p] updates and o_OUT_STB[p] pulses on the same cycle.
  - RAM commit: the RAM word is written.
- Reset during a write: armed clears. A WE_n rise after reset release without a prior observed fall commits nothing.
- Host load:
  - i_LD_EN writes RAM[LD_ADDR] that cycle and is legal at any time, including during reset.
  - Same cycle as a bus RAM commit: host wins, the bus write is dropped, o_ERR[2] pulses.
  - Same address read the following cycle returns the new word.

Decomposition:
- Shared package ika32010_pkg: PORT_WINDOW_MASK (12'hFF8), NOP_WORD (16'h7F80), ERR_* bit indices.
- One sub-module: ika32010_bus_edge. It holds the history registers for MEN_n/DEN_n/WE_n and emits fall/rise pulses; all strobe decoding uses it.
- RAM is inferred inline, one write port, one read port.

Test Plan:
- Fetch: host-load RAM[0x000]=7F89, RAM[0x001]=7EE0, then release RS_n → o_DIN shows 7F89 then 7EE0 one EMUCLK after each MEN_n-low address.
- OUT: WE_n low, ADDR=0x003, DOUT=1234, WE_n high → o_OUT_DATA[63:48]=1234; o_OUT_STB=8'h08 for exactly one cycle; RAM[0x003] unchanged.
- TBLW: ADDR=0x042, DOUT=00E0 → MEN_n read of 0x042 returns 00E0. Same WE_n rise with i_LD_EN to 0x042 with data BEEF → RAM=BEEF, o_ERR[2] pulses.
- IN, full: push 4E71 to port 1, DEN_n low with ADDR=0x001 → o_DIN=4E71; on DEN_n rise o_IN_ACK=8'h02 and FULL[1]=0.
- IN, empty: second read of port 1 → o_DIN=4E71, o_ERR[0] pulses. Double push (AAAA then 5555) → o_ERR[1] pulses and a read returns 5555.
- Reset mid-write: WE_n low, assert RS_n, release RS_n, then WE_n high → no o_OUT_STB, outputs stay 0.
